// File: rtl/mpu_store.sv
// Streams one matrix from the register file to a valid/ready sink, row-major, with row/col tags.
// Latency: en -> first element on out_valid after 3 cycles, then 1 element/cycle; done 1 cycle after last.
// Backpressure: a 2-entry buffer plus one in-flight read; reads stall when 2 are outstanding, output holds.
module mpu_store #(
    parameter int FP              = 32,
    parameter int M               = 4,
    parameter int N               = 4,
    parameter int MBITS           = 2,
    parameter int NBITS           = 2,
    parameter int MATRIX_REG_SIZE = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [MATRIX_REG_SIZE-1:0] store_addr,
    output logic                       ack,
    output logic                       busy,
    output logic                       error,
    output logic                       done,
    output logic                       reg_store_en,
    output logic [MATRIX_REG_SIZE-1:0] reg_store_addr,
    output logic [MBITS:0]             reg_m_in,
    output logic [NBITS:0]             reg_n_in,
    input  logic [FP-1:0]              reg_element_in,
    input  logic [MBITS:0]             reg_m_size,
    input  logic [NBITS:0]             reg_n_size,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [FP-1:0]              element_out,
    output logic [MBITS:0]             out_row,
    output logic [NBITS:0]             out_col,
    output logic                       out_last
);

    typedef enum logic [1:0] {IDLE, SIZE, STREAM} state_t;

    localparam logic [MBITS:0] M_ONE = (MBITS+1)'(1);
    localparam logic [NBITS:0] N_ONE = (NBITS+1)'(1);
    localparam logic [MBITS:0] M_MAX = (MBITS+1)'(M);
    localparam logic [NBITS:0] N_MAX = (NBITS+1)'(N);

    state_t                     state;
    logic [MATRIX_REG_SIZE-1:0] addr_q;
    logic [MBITS:0]             m_q, rd_row, fl_row;
    logic [NBITS:0]             n_q, rd_col, fl_col;
    logic                       issued_all;
    logic                       inflight;

    // two-entry buffer for returned read data and its tags
    logic [FP-1:0]              buf_dat [2];
    logic [MBITS:0]             buf_row [2];
    logic [NBITS:0]             buf_col [2];
    logic                       wr_ptr, rd_ptr;
    logic [1:0]                 count;
    logic [1:0]                 occ;

    logic                       dims_bad;
    logic                       buf_head;
    logic                       pop, push, pop_buf;
    logic [FP-1:0]              head_dat;
    logic [MBITS:0]             head_row;
    logic [NBITS:0]             head_col;

    // issue control, output head selection (empty buffer bypasses the arriving read data)
    always_comb begin
        ack            = (state == IDLE) && en;
        busy           = (state != IDLE);
        reg_store_addr = addr_q;
        reg_m_in       = rd_row;
        reg_n_in       = rd_col;
        occ            = count + {1'b0, inflight};
        reg_store_en   = (state == STREAM) && !issued_all && (occ < 2'd2);
        dims_bad       = (reg_m_size == '0) || (reg_n_size == '0) ||
                         (reg_m_size > M_MAX) || (reg_n_size > N_MAX);
        buf_head       = (count != 2'd0);
        head_dat       = buf_head ? buf_dat[rd_ptr] : reg_element_in;
        head_row       = buf_head ? buf_row[rd_ptr] : fl_row;
        head_col       = buf_head ? buf_col[rd_ptr] : fl_col;
        out_valid      = (state == STREAM) && (buf_head || inflight);
        element_out    = out_valid ? head_dat : '0;
        out_row        = out_valid ? head_row : '0;
        out_col        = out_valid ? head_col : '0;
        out_last       = out_valid && (head_row == m_q - M_ONE) && (head_col == n_q - N_ONE);
        pop            = out_valid && out_ready;
        push           = inflight && !(!buf_head && pop);
        pop_buf        = pop && buf_head;
    end

    // control FSM: request acceptance, dimension check, read pointer walk, completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            m_q        <= '0;
            n_q        <= '0;
            rd_row     <= '0;
            rd_col     <= '0;
            fl_row     <= '0;
            fl_col     <= '0;
            issued_all <= 1'b0;
            inflight   <= 1'b0;
            error      <= 1'b0;
            done       <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= reg_store_en;
            if (reg_store_en) begin
                fl_row <= rd_row;
                fl_col <= rd_col;
            end
            case (state)
                IDLE: begin
                    if (en) begin
                        addr_q <= store_addr;
                        error  <= 1'b0;
                        state  <= SIZE;
                    end
                end
                SIZE: begin
                    if (dims_bad) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end else begin
                        m_q        <= reg_m_size;
                        n_q        <= reg_n_size;
                        rd_row     <= '0;
                        rd_col     <= '0;
                        issued_all <= 1'b0;
                        state      <= STREAM;
                    end
                end
                STREAM: begin
                    if (reg_store_en) begin
                        if (rd_col == n_q - N_ONE) begin
                            rd_col <= '0;
                            if (rd_row == m_q - M_ONE) issued_all <= 1'b1;
                            else                       rd_row     <= rd_row + M_ONE;
                        end else begin
                            rd_col <= rd_col + N_ONE;
                        end
                    end
                    if (pop && out_last) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // buffer occupancy and pointers; simultaneous push and pop keeps occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push)    wr_ptr <= ~wr_ptr;
            if (pop_buf) rd_ptr <= ~rd_ptr;
            if (push && !pop_buf)      count <= count + 2'd1;
            else if (!push && pop_buf) count <= count - 2'd1;
        end
    end

    // buffer storage; contents are don't-care while count is zero
    always_ff @(posedge clk) begin
        if (push) begin
            buf_dat[wr_ptr] <= reg_element_in;
            buf_row[wr_ptr] <= fl_row;
            buf_col[wr_ptr] <= fl_col;
        end
    end

endmodule
